// File: rtl/seq_detector_param_if.sv
// Serial-stream and status bundle for seq_detector_param.
// The master side drives the stream and controls; the slave side is the detector.
interface seq_detector_param_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN) + 1;

    logic               x;
    logic               x_valid;
    logic               overlap;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_in;
    logic [LEN_W-1:0]   len_in;
    logic               cnt_clr;
    logic               y;
    logic               y_q;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output x, x_valid, overlap, pat_load, pat_in, len_in, cnt_clr,
        input  y, y_q, match_cnt
    );

    modport slave (
        input  x, x_valid, overlap, pat_load, pat_in, len_in, cnt_clr,
        output y, y_q, match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (length 2..MAX_LEN) with overlap control,
// registered match copy and saturating match counter.
module seq_detector_param #(
    parameter int unsigned        MAX_LEN = 8,
    parameter int unsigned        CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(8'b0000_1011),
    parameter int unsigned        RST_LEN = 4,
    localparam int unsigned       LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_detector_param_if.slave  bus
);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic               len_ok;
    logic               y;

    always_comb begin
        cand = {hist_q[MAX_LEN-2:0], bus.x};
        mask = '0;
        // Only the low len_q bits of pattern and history take part in the compare.
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        len_ok = (bus.len_in >= LEN_W'(2)) && (bus.len_in <= LEN_W'(MAX_LEN));
        y = ~reset & bus.x_valid & ~bus.pat_load &
            (fill_q >= (len_q - LEN_W'(1))) &
            ((cand & mask) == (pat_q & mask));
    end

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (bus.pat_load) begin
            if (len_ok) begin
                pat_d = bus.pat_in;
                len_d = bus.len_in;
            end
            hist_d = '0;
            fill_d = '0;
        end else if (bus.x_valid) begin
            hist_d = cand;
            if (y && !bus.overlap) begin
                fill_d = '0;
            end else if (fill_q < len_q) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (y && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q   <= RST_PAT;
            len_q   <= LEN_W'(RST_LEN);
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= y;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.y         = y;
    assign bus.y_q       = match_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Runtime-programmable serial bit-pattern detector. It generalises the fixed 1011 Mealy detector to any pattern of length 2..MAX_LEN. It adds overlapping and non-overlapping match modes, an input-valid qualifier, a registered (Moore-style) output copy and a saturating match counter. It sits on a single-bit serial stream, alongside or in place of the fixed-pattern detectors in this design.

## Interface
Parameters:
- MAX_LEN, 8, maximum pattern length (legal 2..16).
- CNT_W, 8, width of the match counter.
- RST_PAT, 8'b0000_1011, pattern loaded at reset (MAX_LEN bits wide).
- RST_LEN, 4, pattern length loaded at reset.
- LEN_W, $clog2(MAX_LEN)+1, width of len_in (derived, do not override).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only on cycles where this is 1.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- pat_load  in  1  load pat_in/len_in on this edge.
- pat_in  in  MAX_LEN  pattern; pat_in[len-1] is the first bit received, pat_in[0] is the last.
- len_in  in  LEN_W  pattern length.
- cnt_clr  in  1  synchronous clear of match_cnt.
- y  out  1  Mealy match, combinational in the current cycle.
- y_q  out  1  y registered; one cycle later.
- match_cnt  out  CNT_W  saturating count of matches.

## Operation
- State registers:
  - pat_r[MAX_LEN-1:0]
  - len_r
  - hist[MAX_LEN-1:0], history shift register with the newest bit at the LSB
  - fill, 0..len_r: count of valid bits eligible for the next match
  - y_q
  - match_cnt
- Reset (async, reset=1):
  - pat_r=RST_PAT, len_r=RST_LEN, hist=0, fill=0.
  - y_q=0, match_cnt=0.
  - y=0 while reset is asserted.
- Match condition (combinational):
  - cand = {hist[MAX_LEN-2:0], x}.
  - y = x_valid & ~pat_load & (fill >= len_r-1) & (cand[len_r-1:0] == pat_r[len_r-1:0]).
  - Bits above len_r are ignored.
- Valid cycle (x_valid=1, pat_load=0):
  - hist <= cand.
  - If y=1 and overlap=0: fill <= 0.
  - Otherwise: fill <= min(fill+1, len_r).
- Idle cycle (x_valid=0, pat_load=0): hist and fill hold; y=0.
- pat_load=1:
  - If 2 <= len_in <= MAX_LEN: pat_r <= pat_in and len_r <= len_in.
  - If len_in is illegal: pat_r and len_r hold. hist and fill are still cleared.
  - Always: hist <= 0, fill <= 0. x is ignored and y=0 in this cycle.
- Counter:
  - cnt_clr=1: match_cnt <= 0. Clear wins; a simultaneous match is not counted.
  - Else if y=1 and match_cnt != all-ones: increment.
  - At all-ones: holds (saturates, no wrap).
- y_q <= y every cycle.
- Overlapping mode, pattern 1011: the trailing "1" of a match may start the next match (1011011 gives 2 matches).
- Non-overlapping mode: a full len_r fresh valid bits are needed after each match.
- Changing overlap mid-stream takes effect on the next match decision. No flush.

## Timing
- y: zero latency, same cycle as the completing x bit.
- y_q and match_cnt: update on the edge that samples the completing bit, visible the next cycle.
- Pattern load: takes effect on the first valid bit after the pat_load edge.
- First match after a load or reset needs len_r valid bits.
- Reset asserted mid-stream:
  - Immediately returns all state to reset values, including RST_PAT; any loaded pattern is lost.
  - No match may span a reset.
- Throughput: one bit per clock; x_valid gaps of any length are transparent.

## Test plan
- Reset defaults, overlap=1, x_valid=1, stream 1,0,1,1,0,1,1 -> y=1 on bits 4 and 7 only. y_q=1 one cycle after each. match_cnt=2.
- Same stream, overlap=0 -> y=1 on bit 4 only; match_cnt=1.
- Stream 1,0,1,1 with x_valid=0 for 3 cycles between each bit (x toggling randomly during gaps) -> exactly one y pulse, on the 4th valid bit.
- pat_load with pat_in=8'b0000_0110, len_in=3, then stream 1,1,0,1,1,0 with overlap=1 -> y on bits 3 and 6.
  - Then pat_load with len_in=9 (illegal) -> pattern 110 retained, history cleared, next match still needs 3 bits.
- CNT_W=2, repeated 1011 with overlap=1 -> match_cnt goes 1,2,3 and holds at 3.
  - cnt_clr asserted on a match cycle -> match_cnt=0 next cycle.
- Reset pulse between bits 3 and 4 of 1011 -> no y when bit 4 arrives. All outputs are 0 during reset, and the default pattern is restored.
